pipeline_hazard_ctrl: RTL

Hazard and bypass controller for the RF/EXE register-file stage. Tracks destination registers of in-flight EXE/MEM/WB instructions and produces registered bypass selects for the RF operand muxes. Generates rf_stall for load-use interlocks, WB read-during-write collisions and HI/LO multiply/divide busy. Sits between decode and the RF stage.

---
 rtl/pipeline_hazard_ctrl_pkg.sv | 27 ++
 rtl/hazard_muldiv_timer.sv | 30 +++
 rtl/pipeline_hazard_ctrl.sv | 127 ++++++++++++
 3 files changed

// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared bypass select codes and in-flight slot layout for the RF/EXE hazard controller.
package pipeline_hazard_ctrl_pkg;

  localparam logic [1:0] RF_A_REGFILE    = 2'd0;
  localparam logic [1:0] RF_A_EXE_BYPASS = 2'd1;
  localparam logic [1:0] RF_A_MEM_BYPASS = 2'd2;
  localparam logic [1:0] RF_A_RB_BYPASS  = 2'd3;

  localparam logic [2:0] RF_B_REGFILE    = 3'd0;
  localparam logic [2:0] RF_B_EXE_BYPASS = 3'd1;
  localparam logic [2:0] RF_B_MEM_BYPASS = 3'd2;
  localparam logic [2:0] RF_B_INST_BYPASS = 3'd3;
  localparam logic [2:0] RF_B_RB_BYPASS  = 3'd4;

  typedef struct packed {
    logic       valid;
    logic [4:0] dest;
    logic       is_load;
  } slot_t;

  localparam slot_t SLOT_EMPTY = '0;

  function automatic logic slot_match(input slot_t s, input logic [4:0] idx);
    return s.valid && (s.dest == idx);
  endfunction

endpackage

// File: rtl/hazard_muldiv_timer.sv
// HI/LO unit occupancy timer: loads on an issued mult/div, counts down every cycle.
module hazard_muldiv_timer #(
  parameter int MULT_CYCLES = 6,
  parameter int DIV_CYCLES  = 36,
  parameter int CNT_W       = 6
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_load_mult,
  input  logic i_load_div,
  output logic o_busy
);

  logic [CNT_W-1:0] r_cnt;

  // Counts through mem_stall: the HI/LO unit is not frozen by the pipe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_cnt <= '0;
    else if (i_load_div)
      r_cnt <= CNT_W'(DIV_CYCLES);
    else if (i_load_mult)
      r_cnt <= CNT_W'(MULT_CYCLES);
    else if (r_cnt != '0)
      r_cnt <= r_cnt - 1'b1;
  end

  assign o_busy = (r_cnt != '0);

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// RF/EXE hazard and bypass controller: registered operand selects plus rf_stall interlocks.
// Optional WB_HOLD_BYPASS_EN: WB collisions use the RF-stage write-back bypass instead of stalling.
module pipeline_hazard_ctrl
  import pipeline_hazard_ctrl_pkg::*;
#(
  parameter int MULT_CYCLES = 6,
  parameter int DIV_CYCLES  = 36,
  parameter int CNT_W       = 6
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       id_valid,
  input  logic [4:0] id_rs,
  input  logic [4:0] id_rt,
  input  logic       id_use_rs,
  input  logic       id_use_rt,
  input  logic       id_use_imm,
  input  logic [4:0] id_dest,
  input  logic       id_is_load,
  input  logic       id_is_mult,
  input  logic       id_is_div,
  input  logic       id_reads_hilo,
  input  logic       mem_stall,
  input  logic       exe_flush,
  output logic       rf_stall,
  output logic [1:0] exe_a_bypass,
  output logic [2:0] exe_b_bypass,
  output logic       muldiv_busy
);

  slot_t r_exe, r_mem, r_wb;
  logic [1:0] r_a_sel, w_a_sel;
  logic [2:0] r_b_sel, w_b_sel;

  logic w_chk_a, w_chk_b;
  logic w_a_exe, w_a_mem, w_a_wb;
  logic w_b_exe, w_b_mem, w_b_wb;
  logic w_load_use, w_wb_coll, w_hilo_hold, w_busy;
  logic w_kill, w_issue;

  // Operand B compare is skipped when B is the immediate.
  assign w_chk_a = id_use_rs;
  assign w_chk_b = id_use_rt && !id_use_imm;

  assign w_a_exe = slot_match(r_exe, id_rs);
  assign w_a_mem = slot_match(r_mem, id_rs);
  assign w_a_wb  = slot_match(r_wb,  id_rs);
  assign w_b_exe = slot_match(r_exe, id_rt);
  assign w_b_mem = slot_match(r_mem, id_rt);
  assign w_b_wb  = slot_match(r_wb,  id_rt);

  assign w_load_use = r_exe.is_load &&
                      ((w_chk_a && w_a_exe) || (w_chk_b && w_b_exe));
  assign w_wb_coll  = (w_chk_a && !w_a_exe && !w_a_mem && w_a_wb) ||
                      (w_chk_b && !w_b_exe && !w_b_mem && w_b_wb);
  assign w_hilo_hold = w_busy && (id_reads_hilo || id_is_mult || id_is_div);

`ifdef WB_HOLD_BYPASS_EN
  assign rf_stall = id_valid && (w_load_use || w_hilo_hold);
`else
  assign rf_stall = id_valid && (w_load_use || w_hilo_hold || w_wb_coll);
`endif

  always_comb begin
    w_a_sel = RF_A_REGFILE;
    if (w_chk_a) begin
      if (w_a_exe)      w_a_sel = RF_A_EXE_BYPASS;
      else if (w_a_mem) w_a_sel = RF_A_MEM_BYPASS;
`ifdef WB_HOLD_BYPASS_EN
      else if (w_a_wb)  w_a_sel = RF_A_RB_BYPASS;
`endif
    end
    w_b_sel = RF_B_REGFILE;
    if (id_use_imm)
      w_b_sel = RF_B_INST_BYPASS;
    else if (w_chk_b) begin
      if (w_b_exe)      w_b_sel = RF_B_EXE_BYPASS;
      else if (w_b_mem) w_b_sel = RF_B_MEM_BYPASS;
`ifdef WB_HOLD_BYPASS_EN
      else if (w_b_wb)  w_b_sel = RF_B_RB_BYPASS;
`endif
    end
  end

  assign w_kill  = rf_stall || exe_flush || !id_valid;
  assign w_issue = !mem_stall && !w_kill;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_exe   <= SLOT_EMPTY;
      r_mem   <= SLOT_EMPTY;
      r_wb    <= SLOT_EMPTY;
      r_a_sel <= RF_A_REGFILE;
      r_b_sel <= RF_B_REGFILE;
    end else if (!mem_stall) begin
      r_wb  <= r_mem;
      r_mem <= r_exe;
      if (w_kill) begin
        r_exe   <= SLOT_EMPTY;
        r_a_sel <= RF_A_REGFILE;
        r_b_sel <= RF_B_REGFILE;
      end else begin
        r_exe   <= '{valid: (id_dest != 5'd0), dest: id_dest,
                     is_load: id_is_load && (id_dest != 5'd0)};
        r_a_sel <= w_a_sel;
        r_b_sel <= w_b_sel;
      end
    end
  end

  hazard_muldiv_timer #(
    .MULT_CYCLES(MULT_CYCLES),
    .DIV_CYCLES (DIV_CYCLES),
    .CNT_W      (CNT_W)
  ) u_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_load_mult(w_issue && id_is_mult),
    .i_load_div (w_issue && id_is_div),
    .o_busy     (w_busy)
  );

  assign exe_a_bypass = r_a_sel;
  assign exe_b_bypass = r_b_sel;
  assign muldiv_busy  = w_busy;

endmodule
